sprite_animator: RTL and testbench
==================================

Name: sprite_animator

Overview:
Per-sprite animation and motion controller. Replaces hand-written frame-select and position logic in top modules.
- Advances a multi-frame sprite through a configurable frame sequence (loop or ping-pong).
- Moves the sprite in X and Y with wrap or bounce at the screen edges.
- Issues the line-start pulse for the sprite engine.
- Sits between display timings and the sprite engine/ROM; one instance per sprite.

Parameters:
CORDW, 12, screen coordinate width in bits
ADDRW, 11, sprite ROM address width
FRAMES, 3, animation frames in graphic (>=1)
FRAME_PIXELS, 640, ROM entries per frame (width*height)
TICKS_PER_FRAME, 16, frame_tick pulses per animation step (>=1)
ANIM_MODE, ANIM_LOOP, ANIM_LOOP or ANIM_PINGPONG
EDGE_MODE, EDGE_WRAP, EDGE_WRAP or EDGE_BOUNCE
H_RES, 1920, active width
V_RES, 1080, active height
H_RES_FULL, 2200, total width incl. blanking
V_RES_FULL, 1125, total height incl. blanking
SPR_W_PX, 384, on-screen sprite width after scaling
SPR_H_PX, 240, on-screen sprite height after scaling
SPEED_X, 6, pixels moved per frame_tick in X
SPEED_Y, 0, pixels moved per frame_tick in Y
START_X, 0, reset X position
START_Y, 420, reset Y position

Ports:
clk_pix  in  1  pixel clock
rst  in  1  reset, synchronous, active-high
enable  in  1  animation/motion enable
frame_tick  in  1  one-cycle pulse once per video frame (start of vertical blanking)
sx  in  CORDW  current screen x
sy  in  CORDW  current screen y
sprx  out  CORDW  sprite x position
spry  out  CORDW  sprite y position
spr_base_addr  out  ADDRW  ROM base address of current frame
frame_idx  out  $clog2(FRAMES)+1  current frame number
flip_x  out  1  sprite moving right (mirror the art)
spr_start  out  1  one-cycle start pulse to sprite engine

Behaviour:
- Reset (one clk_pix cycle): sprx=START_X, spry=START_Y, frame_idx=0, spr_base_addr=0, flip_x=0, spr_start=0. Internal tick_cnt=0, anim_dir=forward, dir_x=left, dir_y=down. Reset wins over a coincident frame_tick.
- A step occurs on a cycle with frame_tick && enable. With enable low, frame_tick is ignored and all state holds.
- Animation on each step:
  - If tick_cnt==TICKS_PER_FRAME-1, tick_cnt=0 and the frame advances; otherwise tick_cnt+1.
  - LOOP: frame_idx wraps FRAMES-1 -> 0.
  - PINGPONG: sequence 0,1,..,F-1,F-2,..,1,0,1..; direction reverses on reaching either end, with no repeated end frame.
  - FRAMES==1: frame_idx stays 0.
- spr_base_addr tracks frame_idx*FRAME_PIXELS by adding or subtracting FRAME_PIXELS (resetting to 0 on wrap). No multiplier. It updates in the same cycle as frame_idx.
- Motion on each step (registered; new sprx/spry visible the cycle after frame_tick):
  - WRAP, left: sprx>SPEED_X ? sprx-SPEED_X : H_RES_FULL-(SPEED_X-sprx).
  - WRAP, right: (sprx+SPEED_X>=H_RES_FULL) ? sprx+SPEED_X-H_RES_FULL : sprx+SPEED_X.
  - Sums are computed at CORDW+1 bits.
  - BOUNCE, left: if sprx<=SPEED_X then sprx=0 and dir_x flips to right.
  - BOUNCE, right: if sprx+SPEED_X>=H_RES-SPR_W_PX then sprx=H_RES-SPR_W_PX and dir_x flips to left.
  - Y uses identical rules with SPEED_Y, V_RES_FULL and V_RES-SPR_H_PX; down = increasing y.
  - SPEED==0 on an axis: position and direction on that axis never change.
- flip_x = (dir_x==right), registered with dir_x.
- spr_start:
  - spry_cor = (spry==0) ? V_RES_FULL-1 : spry-1.
  - spr_start is registered high for exactly one cycle, on the cycle after (sy==spry_cor && sx==H_RES-1). It is therefore high while sx==H_RES.
  - It fires independently of enable; it is 0 during reset.
- Elaboration checks ($error): FRAMES>=1, TICKS_PER_FRAME>=1, SPEED_X<H_RES_FULL, SPEED_Y<V_RES_FULL, FRAMES*FRAME_PIXELS<=2**ADDRW.

Decomposition:
- sprite_pkg: anim_mode_t {ANIM_LOOP, ANIM_PINGPONG}; edge_mode_t {EDGE_WRAP, EDGE_BOUNCE}; dir_t {DIR_NEG, DIR_POS}.
- Sub-module sprite_axis_mover, instanced for X and Y.
  - Parameters: CORDW, EDGE_MODE, SPEED, LIMIT_FULL, LIMIT_BOUNCE, START, START_DIR.
  - Ports: clk_pix, rst, step, pos, dir.

Test Plan:
1. Reset, then 48 frame_tick with defaults (LOOP, TICKS=16) -> spr_base_addr 0 (ticks 1-15), 640 (ticks 16-31), 1280 (ticks 32-47), 0 after tick 48; frame_idx 0,1,2,0.
2. PINGPONG, FRAMES=3, TICKS=1, 6 ticks -> frame_idx 1,2,1,0,1,2; base 640,1280,640,0,640,1280.
3. WRAP left from sprx=0, SPEED_X=6 -> sprx 2194, then 2188; with sprx=4 -> 2198.
4. BOUNCE from sprx=10, left -> 4, then 0 with flip_x=1, then 6. Start 1530 moving right -> 1536 with flip_x=0 (1920-384).
5. spry=420: pulse sy=419, sx=1919 -> spr_start high only at the next cycle. spry=0 -> fires on sy=1124.
6. enable=0 with 20 frame_ticks -> no change. frame_tick coincident with rst -> reset values, tick_cnt=0.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types for the sprite animation/motion controller.
package sprite_pkg;

  typedef enum logic {ANIM_LOOP, ANIM_PINGPONG} anim_mode_t;
  typedef enum logic {EDGE_WRAP, EDGE_BOUNCE} edge_mode_t;
  typedef enum logic {DIR_NEG, DIR_POS} dir_t;

endpackage

// File: rtl/sprite_axis_mover.sv
// One-axis sprite position register with wrap-around or bounce at the screen edges.
module sprite_axis_mover
  import sprite_pkg::*;
#(
  parameter int         CORDW        = 12,
  parameter edge_mode_t EDGE_MODE    = EDGE_WRAP,
  parameter int         SPEED        = 6,
  parameter int         LIMIT_FULL   = 2200,
  parameter int         LIMIT_BOUNCE = 1536,
  parameter int         START        = 0,
  parameter dir_t       START_DIR    = DIR_NEG
) (
  input  logic             clk_pix,
  input  logic             rst,
  input  logic             step,
  output logic [CORDW-1:0] pos,
  output dir_t             dir
);

  localparam logic [CORDW:0] SPD  = (CORDW+1)'(SPEED);
  localparam logic [CORDW:0] FULL = (CORDW+1)'(LIMIT_FULL);
  localparam logic [CORDW:0] BND  = (CORDW+1)'(LIMIT_BOUNCE);

  logic [CORDW:0]   pos_w, inc, dec;
  logic [CORDW-1:0] pos_next;
  dir_t             dir_next;

  // Arithmetic is one bit wider than the coordinate so edge compares never overflow.
  always_comb begin
    pos_w    = {1'b0, pos};
    inc      = pos_w + SPD;
    dec      = pos_w - SPD;
    pos_next = pos;
    dir_next = dir;
    if (SPEED != 0) begin
      if (EDGE_MODE == EDGE_WRAP) begin
        if (dir == DIR_NEG)
          pos_next = CORDW'((pos_w > SPD) ? dec : FULL - (SPD - pos_w));
        else
          pos_next = CORDW'((inc >= FULL) ? inc - FULL : inc);
      end else if (dir == DIR_NEG) begin
        if (pos_w <= SPD) begin
          pos_next = '0;
          dir_next = DIR_POS;
        end else begin
          pos_next = CORDW'(dec);
        end
      end else if (inc >= BND) begin
        pos_next = CORDW'(BND);
        dir_next = DIR_NEG;
      end else begin
        pos_next = CORDW'(inc);
      end
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      pos <= CORDW'(START);
      dir <= START_DIR;
    end else if (step) begin
      pos <= pos_next;
      dir <= dir_next;
    end
  end

endmodule

// File: rtl/sprite_animator.sv
// Per-sprite controller: frame sequencing, ROM base address, X/Y motion and line-start pulse.
module sprite_animator
  import sprite_pkg::*;
#(
  parameter int         CORDW           = 12,
  parameter int         ADDRW           = 11,
  parameter int         FRAMES          = 3,
  parameter int         FRAME_PIXELS    = 640,
  parameter int         TICKS_PER_FRAME = 16,
  parameter anim_mode_t ANIM_MODE       = ANIM_LOOP,
  parameter edge_mode_t EDGE_MODE       = EDGE_WRAP,
  parameter int         H_RES           = 1920,
  parameter int         V_RES           = 1080,
  parameter int         H_RES_FULL      = 2200,
  parameter int         V_RES_FULL      = 1125,
  parameter int         SPR_W_PX        = 384,
  parameter int         SPR_H_PX        = 240,
  parameter int         SPEED_X         = 6,
  parameter int         SPEED_Y         = 0,
  parameter int         START_X         = 0,
  parameter int         START_Y         = 420
) (
  input  logic                     clk_pix,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     frame_tick,
  input  logic [CORDW-1:0]         sx,
  input  logic [CORDW-1:0]         sy,
  output logic [CORDW-1:0]         sprx,
  output logic [CORDW-1:0]         spry,
  output logic [ADDRW-1:0]         spr_base_addr,
  output logic [$clog2(FRAMES):0]  frame_idx,
  output logic                     flip_x,
  output logic                     spr_start
);

  localparam int FW = $clog2(FRAMES) + 1;
  localparam int TW = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
  localparam logic [TW-1:0]    TICK_LAST  = TW'(TICKS_PER_FRAME - 1);
  localparam logic [FW-1:0]    FRAME_LAST = FW'(FRAMES - 1);
  localparam logic [ADDRW-1:0] FP         = ADDRW'(FRAME_PIXELS);

  if (FRAMES < 1) begin : g_chk_frames
    $error("FRAMES must be at least 1");
  end
  if (TICKS_PER_FRAME < 1) begin : g_chk_ticks
    $error("TICKS_PER_FRAME must be at least 1");
  end
  if (SPEED_X >= H_RES_FULL || SPEED_Y >= V_RES_FULL) begin : g_chk_speed
    $error("sprite speed must be below the full raster size");
  end
  if (FRAMES * FRAME_PIXELS > (1 << ADDRW)) begin : g_chk_rom
    $error("frame graphics do not fit the ROM address range");
  end

  logic             step, adv;
  logic [TW-1:0]    tick_cnt;
  dir_t             anim_dir, anim_dir_next, dir_x;
  logic [FW-1:0]    idx_next;
  logic [ADDRW-1:0] base_next;
  logic [CORDW-1:0] spry_cor;

  assign step = frame_tick && enable;
  assign adv  = step && (tick_cnt == TICK_LAST);

  // Base address follows the frame index by +/- FRAME_PIXELS so no multiplier is needed.
  always_comb begin
    idx_next      = frame_idx;
    base_next     = spr_base_addr;
    anim_dir_next = anim_dir;
    if (adv && FRAMES > 1) begin
      if (ANIM_MODE == ANIM_LOOP) begin
        if (frame_idx == FRAME_LAST) begin
          idx_next  = '0;
          base_next = '0;
        end else begin
          idx_next  = frame_idx + FW'(1);
          base_next = spr_base_addr + FP;
        end
      end else if (anim_dir == DIR_POS) begin
        if (frame_idx == FRAME_LAST) begin
          idx_next      = frame_idx - FW'(1);
          base_next     = spr_base_addr - FP;
          anim_dir_next = DIR_NEG;
        end else begin
          idx_next  = frame_idx + FW'(1);
          base_next = spr_base_addr + FP;
        end
      end else begin
        if (frame_idx == '0) begin
          idx_next      = FW'(1);
          base_next     = FP;
          anim_dir_next = DIR_POS;
        end else begin
          idx_next  = frame_idx - FW'(1);
          base_next = spr_base_addr - FP;
        end
      end
    end
  end

  // Start pulse leads the sprite's first line by one line so the engine can prefetch.
  assign spry_cor = (spry == '0) ? CORDW'(V_RES_FULL - 1) : spry - CORDW'(1);

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      tick_cnt      <= '0;
      frame_idx     <= '0;
      spr_base_addr <= '0;
      anim_dir      <= DIR_POS;
      spr_start     <= 1'b0;
    end else begin
      if (step) tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
      frame_idx     <= idx_next;
      spr_base_addr <= base_next;
      anim_dir      <= anim_dir_next;
      spr_start     <= (sy == spry_cor) && (sx == CORDW'(H_RES - 1));
    end
  end

  sprite_axis_mover #(
    .CORDW(CORDW), .EDGE_MODE(EDGE_MODE), .SPEED(SPEED_X), .LIMIT_FULL(H_RES_FULL),
    .LIMIT_BOUNCE(H_RES - SPR_W_PX), .START(START_X), .START_DIR(DIR_NEG)
  ) u_move_x (
    .clk_pix(clk_pix), .rst(rst), .step(step), .pos(sprx), .dir(dir_x)
  );

  sprite_axis_mover #(
    .CORDW(CORDW), .EDGE_MODE(EDGE_MODE), .SPEED(SPEED_Y), .LIMIT_FULL(V_RES_FULL),
    .LIMIT_BOUNCE(V_RES - SPR_H_PX), .START(START_Y), .START_DIR(DIR_POS)
  ) u_move_y (
    .clk_pix(clk_pix), .rst(rst), .step(step), .pos(spry), .dir()
  );

  assign flip_x = (dir_x == DIR_POS);

endmodule

// File: tb/tb_sprite_animator.sv
// Directed bench for sprite_animator: several instances with different modes share one stimulus.
module tb_sprite_animator;
  import sprite_pkg::*;

  logic        clk_pix = 1'b0;
  logic        rst, frame_tick;
  logic [5:0]  en;
  logic [11:0] sx, sy;
  logic [11:0] sprx_a [6];
  logic [11:0] spry_a [6];
  logic [10:0] base_a [6];
  logic [2:0]  idx_a  [5];
  logic [0:0]  idx5;
  logic        flip_a  [6];
  logic        start_a [6];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_pix = ~clk_pix;

  // 0: defaults (LOOP, WRAP, TICKS=16)
  sprite_animator u0 (.clk_pix(clk_pix), .rst(rst), .enable(en[0]), .frame_tick(frame_tick),
    .sx(sx), .sy(sy), .sprx(sprx_a[0]), .spry(spry_a[0]), .spr_base_addr(base_a[0]),
    .frame_idx(idx_a[0]), .flip_x(flip_a[0]), .spr_start(start_a[0]));
  // 1: ping-pong, one tick per frame
  sprite_animator #(.ANIM_MODE(ANIM_PINGPONG), .TICKS_PER_FRAME(1)) u1 (.clk_pix(clk_pix),
    .rst(rst), .enable(en[1]), .frame_tick(frame_tick), .sx(sx), .sy(sy), .sprx(sprx_a[1]),
    .spry(spry_a[1]), .spr_base_addr(base_a[1]), .frame_idx(idx_a[1]), .flip_x(flip_a[1]),
    .spr_start(start_a[1]));
  // 2: wrap from x=4
  sprite_animator #(.START_X(4)) u2 (.clk_pix(clk_pix), .rst(rst), .enable(en[2]),
    .frame_tick(frame_tick), .sx(sx), .sy(sy), .sprx(sprx_a[2]), .spry(spry_a[2]),
    .spr_base_addr(base_a[2]), .frame_idx(idx_a[2]), .flip_x(flip_a[2]), .spr_start(start_a[2]));
  // 3: bounce from x=10
  sprite_animator #(.EDGE_MODE(EDGE_BOUNCE), .START_X(10)) u3 (.clk_pix(clk_pix), .rst(rst),
    .enable(en[3]), .frame_tick(frame_tick), .sx(sx), .sy(sy), .sprx(sprx_a[3]),
    .spry(spry_a[3]), .spr_base_addr(base_a[3]), .frame_idx(idx_a[3]), .flip_x(flip_a[3]),
    .spr_start(start_a[3]));
  // 4: sprite at y=0, start pulse wraps to the last raster line
  sprite_animator #(.START_Y(0)) u4 (.clk_pix(clk_pix), .rst(rst), .enable(en[4]),
    .frame_tick(frame_tick), .sx(sx), .sy(sy), .sprx(sprx_a[4]), .spry(spry_a[4]),
    .spr_base_addr(base_a[4]), .frame_idx(idx_a[4]), .flip_x(flip_a[4]), .spr_start(start_a[4]));
  // 5: single-frame graphic
  sprite_animator #(.FRAMES(1), .TICKS_PER_FRAME(1)) u5 (.clk_pix(clk_pix), .rst(rst),
    .enable(en[5]), .frame_tick(frame_tick), .sx(sx), .sy(sy), .sprx(sprx_a[5]),
    .spry(spry_a[5]), .spr_base_addr(base_a[5]), .frame_idx(idx5), .flip_x(flip_a[5]),
    .spr_start(start_a[5]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_pix) frame_tick = 1'b1;
      @(negedge clk_pix) frame_tick = 1'b0;
    end
  endtask

  int sx_start [6] = '{0, 0, 4, 10, 0, 0};
  int sy_start [6] = '{420, 420, 420, 420, 0, 420};
  int pp_idx   [8] = '{1, 2, 1, 0, 1, 2, 1, 0};
  int pp_base  [8] = '{640, 1280, 640, 0, 640, 1280, 640, 0};

  initial begin
    rst = 1'b1; frame_tick = 1'b1; en = '1; sx = '0; sy = '0;
    @(negedge clk_pix);
    @(negedge clk_pix);
    rst = 1'b0; frame_tick = 1'b0; en = 6'b000001;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("reset_sprx%0d", k), sprx_a[k], sx_start[k]);
      chk($sformatf("reset_spry%0d", k), spry_a[k], sy_start[k]);
      chk($sformatf("reset_base%0d", k), base_a[k], 0);
      chk($sformatf("reset_flip%0d", k), flip_a[k], 0);
      chk($sformatf("reset_start%0d", k), start_a[k], 0);
    end
    chk("reset_idx0", idx_a[0], 0);

    // LOOP animation, 48 ticks; also wrap-left motion from x=0
    for (int i = 1; i <= 48; i++) begin
      tick(1);
      chk($sformatf("loop_idx_t%0d", i), idx_a[0], (i / 16) % 3);
      chk($sformatf("loop_base_t%0d", i), base_a[0], ((i / 16) % 3) * 640);
      if (i == 1) chk("wrap_x_t1", sprx_a[0], 2194);
      if (i == 2) chk("wrap_x_t2", sprx_a[0], 2188);
    end
    chk("wrap_x_t48", sprx_a[0], 1912);
    chk("y_static", spry_a[0], 420);
    chk("wrap_left_flip", flip_a[0], 0);

    // enable low: ticks ignored
    en = 6'b000000;
    tick(20);
    chk("dis_sprx", sprx_a[0], 1912);
    chk("dis_idx", idx_a[0], 0);
    chk("dis_base", base_a[0], 0);
    chk("dis_u1_idx", idx_a[1], 0);

    // leave tick_cnt at 5, then reset with a coincident frame_tick
    en = 6'b000001;
    tick(5);
    @(negedge clk_pix) begin rst = 1'b1; frame_tick = 1'b1; end
    @(negedge clk_pix) begin rst = 1'b0; frame_tick = 1'b0; end
    chk("rst_tick_sprx", sprx_a[0], 0);
    chk("rst_tick_idx", idx_a[0], 0);
    tick(15);
    chk("rst_cnt_idx15", idx_a[0], 0);
    tick(1);
    chk("rst_cnt_idx16", idx_a[0], 1);
    chk("rst_cnt_base16", base_a[0], 640);
    chk("rst_cnt_sprx16", sprx_a[0], 2104);

    // ping-pong
    en = 6'b000010;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk($sformatf("pp_idx_t%0d", i + 1), idx_a[1], pp_idx[i]);
      chk($sformatf("pp_base_t%0d", i + 1), base_a[1], pp_base[i]);
    end

    // wrap left from x=4
    en = 6'b000100;
    tick(1);
    chk("wrap4_t1", sprx_a[2], 2198);
    tick(1);
    chk("wrap4_t2", sprx_a[2], 2192);

    // bounce
    en = 6'b001000;
    tick(1);
    chk("bnc_t1", sprx_a[3], 4);
    chk("bnc_t1_flip", flip_a[3], 0);
    tick(1);
    chk("bnc_t2", sprx_a[3], 0);
    chk("bnc_t2_flip", flip_a[3], 1);
    tick(1);
    chk("bnc_t3", sprx_a[3], 6);
    tick(254);
    chk("bnc_t257", sprx_a[3], 1530);
    chk("bnc_t257_flip", flip_a[3], 1);
    tick(1);
    chk("bnc_t258", sprx_a[3], 1536);
    chk("bnc_t258_flip", flip_a[3], 0);
    tick(1);
    chk("bnc_t259", sprx_a[3], 1530);

    // single frame graphic
    en = 6'b100000;
    tick(3);
    chk("f1_idx", idx5, 0);
    chk("f1_base", base_a[5], 0);
    chk("f1_sprx", sprx_a[5], 2182);

    // spr_start, independent of enable
    en = 6'b000000;
    @(negedge clk_pix) begin sy = 12'd419; sx = 12'd1918; end
    @(negedge clk_pix) chk("start_early", start_a[0], 0);
    sx = 12'd1919;
    @(negedge clk_pix) chk("start_hit", start_a[0], 1);
    chk("start_hit_u4", start_a[4], 0);
    sx = 12'd1920;
    @(negedge clk_pix) chk("start_after", start_a[0], 0);
    sy = 12'd420; sx = 12'd1919;
    @(negedge clk_pix) chk("start_wrong_line", start_a[0], 0);
    sy = 12'd1124; sx = 12'd1919;
    @(negedge clk_pix) chk("start_y0_hit", start_a[4], 1);
    chk("start_y0_u0", start_a[0], 0);
    sx = 12'd0; sy = 12'd0;
    @(negedge clk_pix) chk("start_y0_after", start_a[4], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
